ddr_out_serializer: RTL and testbench
=====================================

Name: ddr_out_serializer

Overview:
Parallel-to-DDR serializer that feeds the per-lane DDR output cells of an external-memory/display interface. It accepts words over a valid/ready handshake and emits 2*N_LANES bits per clk as registered dp/dn pairs. The first half of each pair is driven at posedge and the second half at negedge by the downstream cell. A one-word holding buffer sustains gapless bursts, and the block also generates output-enable, last-beat and underrun status.

Parameters:
W_DATA, 16, input word width; must be a nonzero multiple of 2*N_LANES
N_LANES, 4, number of DDR pins driven
MSB_FIRST, 1, 1: most-significant bits shifted first; 0: least-significant first
IDLE_LEVEL, 0, value replicated on all out_dp/out_dn bits while idle

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active-low
in_data  in  W_DATA  word to serialize
in_last  in  1  word is final word of burst
in_valid  in  1  in_data/in_last valid
in_ready  out  1  block accepts word this cycle
abort  in  1  synchronous flush of all pending data
out_dp  out  N_LANES  bits for first (posedge) half-period
out_dn  out  N_LANES  bits for second (negedge) half-period
out_oe  out  1  high while a valid beat is on out_dp/out_dn
out_last  out  1  current beat is final beat of an in_last word
underrun  out  1  sticky: shifter ran dry mid-burst
clr_underrun  in  1  clears underrun

Behaviour:
- Reset is asynchronous (rst_n, active-low) on clk domain clk.
- BEATS = W_DATA/(2*N_LANES); the beat counter is max(1,clog2(BEATS)) bits wide and wraps at BEATS-1.
- Reset values: out_dp/out_dn = {N_LANES{IDLE_LEVEL}}, out_oe=0, out_last=0, underrun=0, buffer empty, shifter empty. in_ready is 1 after reset unless abort is asserted.
- in_ready = !abort && !buf_valid (combinational; does not depend on in_valid). Handshake = in_valid && in_ready.
- Shifter is "free" at an edge if it is empty or on its final beat (count==BEATS-1).
- At a posedge where the shifter is free:
  - buf_valid: load buffer into shifter; buffer empties.
  - Otherwise, on a handshake: load in_data into shifter directly (bypass; buffer untouched).
  - Otherwise the shifter becomes empty.
- A handshake that does not bypass writes the buffer.
- Latency: word accepted at edge k into an empty shifter drives beat 0 during cycle k+1. Sustained throughput is one word per BEATS cycles with no idle beats.
- Beat mapping, MSB_FIRST=1, beat b: out_dp = data[W_DATA-1-2Nb -: N], out_dn = data[W_DATA-1-2Nb-N -: N].
- Beat mapping, MSB_FIRST=0: out_dp = data[2Nb +: N], out_dn = data[2Nb+N +: N]. Lane index = bit significance within slice.
- out_dp/out_dn/out_oe/out_last are all registered.
- Idle cycle: outputs = IDLE_LEVEL, out_oe=0.
- out_last=1 only on beat BEATS-1 of a word loaded with in_last=1.
- Underrun: set at an edge where the shifter completes its final beat, the word was not in_last, and no word is loaded. If clr_underrun is asserted on the same edge, the set wins. clr_underrun alone clears the flag.
- Abort: at the next edge, buffer and shifter empty and outputs go idle. in_ready=0 during the abort cycle, so no word is accepted. underrun is unaffected.
- Reset mid-word: everything returns to reset values immediately (async) and the partial word is discarded.
- BEATS==1: bypass every cycle; the buffer is used only if the handshake coincides with a non-free shifter, which cannot occur, so it stays empty.

Decomposition:
- No shared package; BEATS and the counter width are local constants.
- No sub-module. DDR output cells, one per lane, plus one for oe if needed, are instantiated in the parent, fed directly from out_dp/out_dn.

Test Plan:
- Reset: hold rst_n=0 -> out_dp=out_dn=0, out_oe=0, underrun=0, in_ready=1; release -> unchanged while in_valid=0.
- Single word (defaults): in_data=16'hA5C3, in_last=1 accepted edge k -> cycle k+1 dp=4'hA, dn=4'h5, oe=1, last=0; cycle k+2 dp=4'hC, dn=4'h3, oe=1, last=1; cycle k+3 idle oe=0; underrun stays 0.
- Back-to-back: in_valid held with 16'h1234, 16'h5678, 16'h9ABC (last on third) -> oe high 6 consecutive cycles; dp/dn sequence 1/2, 3/4, 5/6, 7/8, 9/A, B/C; in_ready drops while buffer full; no idle beat.
- Underrun: single word 16'hFFFF with in_last=0, then no input -> two beats, idle, underrun=1 from the edge after beat 1; clr_underrun pulse -> 0.
- Abort mid-word: abort asserted during beat 0 of 16'hA5C3 with in_valid high on 16'h1111 -> next cycle idle, oe=0, buffer empty; 16'h1111 not accepted during abort, accepted once abort drops.
- MSB_FIRST=0, 16'hA5C3 -> beat 0 dp=4'h3, dn=4'hC; beat 1 dp=4'h5, dn=4'hA.

Source files
------------

// File: rtl/ddr_out_serializer.sv
// Parallel word to DDR beat serializer with a one-word holding buffer.
// Emits registered dp/dn lane pairs plus oe, last-beat and underrun status.
module ddr_out_serializer #(
   parameter int W_DATA     = 16,
   parameter int N_LANES    = 4,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [W_DATA-1:0]  in_data,
   input  logic               in_last,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               abort,
   output logic [N_LANES-1:0] out_dp,
   output logic [N_LANES-1:0] out_dn,
   output logic               out_oe,
   output logic               out_last,
   output logic               underrun,
   input  logic               clr_underrun
);

   localparam int BEATS = W_DATA / (2 * N_LANES);
   localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);
   localparam logic [N_LANES-1:0] IDLE = {N_LANES{IDLE_LEVEL}};

   logic [W_DATA-1:0] buf_data;
   logic              buf_last;
   logic              buf_valid;
   logic [W_DATA-1:0] sh_data;
   logic              sh_last;
   logic              sh_valid;
   logic [CW-1:0]     cnt;

   logic [W_DATA-1:0] nx_data;
   logic              nx_last;
   logic              nx_valid;
   logic [CW-1:0]     nx_cnt;
   logic [W_DATA-1:0] beat_w;
   logic [N_LANES-1:0] nx_dp;
   logic [N_LANES-1:0] nx_dn;
   logic              hs;
   logic              free;
   logic              dry;

   assign in_ready = !abort && !buf_valid;
   assign hs       = in_valid && in_ready;
   assign free     = !sh_valid || (cnt == LAST_CNT);
   assign dry      = !abort && sh_valid && (cnt == LAST_CNT)
                     && !sh_last && !buf_valid && !hs;

   // Next shifter state; outputs register the beat it selects.
   always_comb begin
      nx_data  = sh_data;
      nx_last  = sh_last;
      nx_valid = sh_valid;
      nx_cnt   = cnt;
      if (abort) begin
         nx_valid = 1'b0;
         nx_cnt   = '0;
      end else if (free) begin
         nx_cnt = '0;
         if (buf_valid) begin
            nx_data  = buf_data;
            nx_last  = buf_last;
            nx_valid = 1'b1;
         end else if (hs) begin
            nx_data  = in_data;
            nx_last  = in_last;
            nx_valid = 1'b1;
         end else begin
            nx_valid = 1'b0;
         end
      end else begin
         nx_cnt = cnt + CW'(1);
      end
   end

   always_comb begin
      if (MSB_FIRST) begin
         beat_w = nx_data << (2 * N_LANES * int'(nx_cnt));
         nx_dp  = beat_w[W_DATA-1 -: N_LANES];
         nx_dn  = beat_w[W_DATA-1-N_LANES -: N_LANES];
      end else begin
         beat_w = nx_data >> (2 * N_LANES * int'(nx_cnt));
         nx_dp  = beat_w[N_LANES-1:0];
         nx_dn  = beat_w[2*N_LANES-1:N_LANES];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_data  <= '0;
         buf_last  <= 1'b0;
         buf_valid <= 1'b0;
         sh_data   <= '0;
         sh_last   <= 1'b0;
         sh_valid  <= 1'b0;
         cnt       <= '0;
         out_dp    <= IDLE;
         out_dn    <= IDLE;
         out_oe    <= 1'b0;
         out_last  <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         sh_data  <= nx_data;
         sh_last  <= nx_last;
         sh_valid <= nx_valid;
         cnt      <= nx_cnt;

         if (abort) begin
            buf_valid <= 1'b0;
         end else if (free && buf_valid) begin
            buf_valid <= 1'b0;
         end else if (hs && !free) begin
            buf_valid <= 1'b1;
            buf_data  <= in_data;
            buf_last  <= in_last;
         end

         if (nx_valid) begin
            out_dp   <= nx_dp;
            out_dn   <= nx_dn;
            out_oe   <= 1'b1;
            out_last <= nx_last && (nx_cnt == LAST_CNT);
         end else begin
            out_dp   <= IDLE;
            out_dn   <= IDLE;
            out_oe   <= 1'b0;
            out_last <= 1'b0;
         end

         if (dry)
            underrun <= 1'b1;
         else if (clr_underrun)
            underrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ddr_out_serializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus.
// Expected beats are queued at each handshake and popped as oe beats appear.
module tb_ddr_out_serializer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        in_valid = 1'b0;
   logic        abort = 1'b0;
   logic        clr_underrun = 1'b0;

   logic        rdy0, oe0, last0, ur0;
   logic [3:0]  dp0, dn0;
   logic        rdy1, oe1, last1, ur1;
   logic [3:0]  dp1, dn1;

   int checks = 0;
   int passed = 0;
   logic [8:0] q0[$];
   logic [8:0] q1[$];
   logic hs_s = 1'b0;
   logic ab_s = 1'b0;
   int oe_run = 0;
   int oe_max = 0;
   int oe_tot = 0;
   bit saw_busy = 1'b0;

   always #5 clk = ~clk;

   ddr_out_serializer #(
      .W_DATA(16), .N_LANES(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)
   ) u_msb (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy0), .abort(abort),
      .out_dp(dp0), .out_dn(dn0), .out_oe(oe0), .out_last(last0),
      .underrun(ur0), .clr_underrun(clr_underrun)
   );

   ddr_out_serializer #(
      .W_DATA(16), .N_LANES(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)
   ) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_last(in_last),
      .in_valid(in_valid), .in_ready(rdy1), .abort(abort),
      .out_dp(dp1), .out_dn(dn1), .out_oe(oe1), .out_last(last1),
      .underrun(ur1), .clr_underrun(clr_underrun)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   always @(posedge clk) begin
      if (!rst_n || ab_s) begin
         q0.delete();
         q1.delete();
      end else if (hs_s) begin
         for (int b = 0; b < 2; b++) begin
            logic [15:0] w;
            logic        l;
            w = in_data;
            l = in_last && (b == 1);
            q0.push_back({l, w[15-8*b -: 4], w[11-8*b -: 4]});
            q1.push_back({l, w[8*b +: 4], w[8*b+4 +: 4]});
         end
      end
   end

   always @(negedge clk) begin
      hs_s = rst_n && in_valid && rdy0;
      ab_s = rst_n && abort;
      if (!rst_n) begin
         oe_run = 0;
      end else begin
         chk("rdy_match", {31'd0, rdy1}, {31'd0, rdy0});
         if (oe0) begin
            oe_run++;
            oe_tot++;
            if (oe_run > oe_max) oe_max = oe_run;
            if (q0.size() == 0) chk("msb_unexp", 32'd1, 32'd0);
            else chk("msb_beat", {23'd0, last0, dp0, dn0},
                     {23'd0, q0.pop_front()});
         end else begin
            oe_run = 0;
            chk("msb_idle", {23'd0, last0, dp0, dn0}, 32'd0);
         end
         if (oe1) begin
            if (q1.size() == 0) chk("lsb_unexp", 32'd1, 32'd0);
            else chk("lsb_beat", {23'd0, last1, dp1, dn1},
                     {23'd0, q1.pop_front()});
         end else begin
            chk("lsb_idle", {23'd0, last1, dp1, dn1}, 32'd0);
         end
      end
   end

   task automatic send(input logic [15:0] w, input logic l);
      int n;
      in_data  = w;
      in_last  = l;
      in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!rdy0 && n < 20) begin
         saw_busy = 1'b1;
         n++;
         @(negedge clk);
      end
      if (n >= 20) chk("send_timeout", 32'd1, 32'd0);
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #12;
      chk("rst_dp", {28'd0, dp0}, 32'd0);
      chk("rst_dn", {28'd0, dn0}, 32'd0);
      chk("rst_oe", {31'd0, oe0}, 32'd0);
      chk("rst_ur", {31'd0, ur0}, 32'd0);
      chk("rst_rdy", {31'd0, rdy0}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle(3);
      chk("post_rst_oe", {31'd0, oe0}, 32'd0);
      chk("post_rst_rdy", {31'd0, rdy0}, 32'd1);

      send(16'hA5C3, 1'b1);
      @(negedge clk);
      chk("sw_b0_oe", {31'd0, oe0}, 32'd1);
      chk("sw_b0_dp", {28'd0, dp0}, 32'hA);
      chk("lsb_b0_dp", {28'd0, dp1}, 32'h3);
      @(negedge clk);
      chk("sw_b1_last", {31'd0, last0}, 32'd1);
      chk("lsb_b1_dn", {28'd0, dn1}, 32'hA);
      @(negedge clk);
      chk("sw_idle_oe", {31'd0, oe0}, 32'd0);
      chk("sw_ur", {31'd0, ur0}, 32'd0);

      idle(2);
      oe_max = 0;
      oe_tot = 0;
      saw_busy = 1'b0;
      send(16'h1234, 1'b0);
      send(16'h5678, 1'b0);
      send(16'h9ABC, 1'b1);
      idle(5);
      chk("b2b_run", oe_max, 32'd6);
      chk("b2b_tot", oe_tot, 32'd6);
      chk("b2b_busy", {31'd0, saw_busy}, 32'd1);
      chk("b2b_ur", {31'd0, ur0}, 32'd0);

      send(16'hFFFF, 1'b0);
      @(negedge clk);
      chk("ur_b0", {31'd0, ur0}, 32'd0);
      @(negedge clk);
      chk("ur_b1", {31'd0, ur0}, 32'd0);
      @(negedge clk);
      chk("ur_set", {31'd0, ur0}, 32'd1);
      chk("ur_set_lsb", {31'd0, ur1}, 32'd1);
      idle(2);
      chk("ur_sticky", {31'd0, ur0}, 32'd1);
      clr_underrun = 1'b1;
      idle(1);
      clr_underrun = 1'b0;
      chk("ur_clr", {31'd0, ur0}, 32'd0);

      send(16'hA5C3, 1'b1);
      abort    = 1'b1;
      in_data  = 16'h1111;
      in_last  = 1'b1;
      in_valid = 1'b1;
      @(negedge clk);
      chk("ab_b0_oe", {31'd0, oe0}, 32'd1);
      chk("ab_rdy", {31'd0, rdy0}, 32'd0);
      @(posedge clk);
      #1 abort = 1'b0;
      @(negedge clk);
      chk("ab_idle", {31'd0, oe0}, 32'd0);
      chk("ab_rdy_back", {31'd0, rdy0}, 32'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("ab_new_dp", {28'd0, dp0}, 32'h1);
      idle(4);

      send(16'h5A5A, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_oe", {31'd0, oe0}, 32'd0);
      chk("mid_rst_dp", {28'd0, dp0}, 32'd0);
      idle(2);
      rst_n = 1'b1;
      idle(3);
      chk("mid_rst_quiet", {31'd0, oe0}, 32'd0);

      for (int i = 0; i < 8; i++) send(16'($urandom), 1'(i == 7));
      idle(6);
      chk("q0_empty", q0.size(), 32'd0);
      chk("q1_empty", q1.size(), 32'd0);
      chk("final_ur", {31'd0, ur0}, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
